// File: rtl/upsample_layer_if.sv
// rtl/upsample_layer_if.sv - pixel stream handshake bundle for upsample_layer
interface upsample_layer_if #(
    parameter int DataWidth = 32
);
    logic                 valid_i;
    logic                 ready_o;
    logic [DataWidth-1:0] data_i;
    logic                 valid_o;
    logic                 ready_i;
    logic [DataWidth-1:0] data_o;
    logic                 last_o;

    // Upsampler side: consumes the input stream, produces the output stream
    modport slave (
        input  valid_i,
        input  data_i,
        input  ready_i,
        output ready_o,
        output valid_o,
        output data_o,
        output last_o
    );

    // Environment side: drives input pixels and downstream ready
    modport master (
        output valid_i,
        output data_i,
        output ready_i,
        input  ready_o,
        input  valid_o,
        input  data_o,
        input  last_o
    );
endinterface

// File: rtl/upsample_layer.sv
// rtl/upsample_layer.sv - streaming nearest-neighbour upsampler (UPSAMPLE_ZERO_INSERT_EN selects zero insertion)
module upsample_layer #(
    parameter int LineWidthPx = 80,
    parameter int LineCountPx = 60,
    parameter int DataWidth   = 32,
    parameter int Scale       = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    upsample_layer_if.slave bus
);

    localparam int XW = (LineWidthPx > 1) ? $clog2(LineWidthPx) : 1;
    localparam int YW = (LineCountPx > 1) ? $clog2(LineCountPx) : 1;
    localparam int RW = (Scale > 1) ? $clog2(Scale) : 1;

    localparam logic [XW-1:0] X_MAX = XW'(LineWidthPx - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(LineCountPx - 1);
    localparam logic [RW-1:0] R_MAX = RW'(Scale - 1);
    localparam bit HAS_REPLAY = (Scale > 1);

    typedef enum logic [0:0] {
        ST_FILL,
        ST_REPLAY
    } state_t;

    state_t               state_q, state_d;
    logic [XW-1:0]        x_in_q, x_in_d;
    logic [YW-1:0]        y_in_q, y_in_d;
    logic [RW-1:0]        h_rep_q, h_rep_d;
    logic [RW-1:0]        v_rep_q, v_rep_d;
    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 last_q, last_d;

    logic                 ready;
    logic                 in_fire;
    logic                 out_fire;
    logic                 h_last, x_last, v_last, y_last;

    // Pixel presented on the next horizontal copy / next replayed column
    logic [DataWidth-1:0] copy_px;
    logic [DataWidth-1:0] replay_px;

    // Counters always describe the pixel in the output register; while the
    // register is empty they point at the position the next input will take.
    always_comb begin
        state_d  = state_q;
        x_in_d   = x_in_q;
        y_in_d   = y_in_q;
        h_rep_d  = h_rep_q;
        v_rep_d  = v_rep_q;
        valid_d  = valid_q;
        data_d   = data_q;
        ready    = 1'b0;

        out_fire = valid_q & bus.ready_i;
        h_last   = (h_rep_q == R_MAX);
        x_last   = (x_in_q == X_MAX);
        v_last   = (v_rep_q == R_MAX);
        y_last   = (y_in_q == Y_MAX);

        case (state_q)
            ST_FILL: begin
                // Refill only on the last copy; never across a row end that starts a replay
                ready = (~valid_q | (bus.ready_i & h_last))
                        & ~(HAS_REPLAY & valid_q & x_last);
                if (out_fire) begin
                    if (!h_last) begin
                        h_rep_d = h_rep_q + RW'(1);
                        data_d  = copy_px;
                    end else begin
                        h_rep_d = '0;
                        valid_d = 1'b0;
                        if (x_last) begin
                            x_in_d = '0;
                            if (HAS_REPLAY) begin
                                state_d = ST_REPLAY;
                                v_rep_d = RW'(1);
                                valid_d = 1'b1;
                                data_d  = replay_px;
                            end else begin
                                y_in_d = y_last ? '0 : y_in_q + YW'(1);
                            end
                        end else begin
                            x_in_d = x_in_q + XW'(1);
                        end
                    end
                end
            end

            ST_REPLAY: begin
                // Input is only taken on the very last beat so the next row starts bubble-free
                ready = bus.ready_i & h_last & x_last & v_last;
                if (out_fire) begin
                    if (!h_last) begin
                        h_rep_d = h_rep_q + RW'(1);
                        data_d  = copy_px;
                    end else begin
                        h_rep_d = '0;
                        if (!x_last) begin
                            x_in_d = x_in_q + XW'(1);
                            data_d = replay_px;
                        end else begin
                            x_in_d = '0;
                            if (v_last) begin
                                state_d = ST_FILL;
                                v_rep_d = '0;
                                y_in_d  = y_last ? '0 : y_in_q + YW'(1);
                                valid_d = 1'b0;
                            end else begin
                                v_rep_d = v_rep_q + RW'(1);
                                data_d  = replay_px;
                            end
                        end
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase

        in_fire = bus.valid_i & ready;
        if (in_fire) begin
            valid_d = 1'b1;
            data_d  = bus.data_i;
            h_rep_d = '0;
        end

        last_d = valid_d & (y_in_d == Y_MAX) & (v_rep_d == R_MAX)
                 & (x_in_d == X_MAX) & (h_rep_d == R_MAX);
    end

    // Control and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_FILL;
            x_in_q  <= '0;
            y_in_q  <= '0;
            h_rep_q <= '0;
            v_rep_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_in_q  <= x_in_d;
            y_in_q  <= y_in_d;
            h_rep_q <= h_rep_d;
            v_rep_q <= v_rep_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

`ifndef UPSAMPLE_ZERO_INSERT_EN
    logic [DataWidth-1:0] linebuf_mem [LineWidthPx];
    logic [XW-1:0]        rd_addr;
    logic [DataWidth-1:0] rd_data_q, rd_data_d;

    // Prefetch address: the column after the one about to be in the output register
    always_comb begin
        rd_addr = '0;
        if (state_d == ST_REPLAY) begin
            rd_addr = (x_in_d == X_MAX) ? '0 : x_in_d + XW'(1);
        end
        rd_data_d = linebuf_mem[rd_addr];
    end

    // Line buffer write on every accepted pixel, registered prefetch read
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            linebuf_mem[x_in_d] <= bus.data_i;
        end
        rd_data_q <= rd_data_d;
    end

    assign copy_px   = data_q;
    assign replay_px = rd_data_q;
`else
    assign copy_px   = '0;
    assign replay_px = '0;
`endif

    assign bus.ready_o = ready;
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.last_o  = last_q;

endmodule

// File: tb/tb_upsample_layer.sv
// tb/tb_upsample_layer.sv - randomized scoreboard bench for upsample_layer
module tb_upsample_layer;

    localparam int DW = 32;
    localparam int LW = 4;
    localparam int LC = 2;
`ifdef UPSAMPLE_ZERO_INSERT_EN
    localparam bit ZI = 1'b1;
`else
    localparam bit ZI = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    upsample_layer_if #(.DataWidth(DW)) if_s1 ();
    upsample_layer_if #(.DataWidth(DW)) if_s2 ();
    upsample_layer_if #(.DataWidth(DW)) if_s3 ();

    upsample_layer #(.LineWidthPx(LW), .LineCountPx(LC), .DataWidth(DW), .Scale(1))
        u_s1 (.clk_i(clk), .rst_i(rst), .bus(if_s1));
    upsample_layer #(.LineWidthPx(LW), .LineCountPx(LC), .DataWidth(DW), .Scale(2))
        u_s2 (.clk_i(clk), .rst_i(rst), .bus(if_s2));
    upsample_layer #(.LineWidthPx(LW), .LineCountPx(LC), .DataWidth(DW), .Scale(3))
        u_s3 (.clk_i(clk), .rst_i(rst), .bus(if_s3));

    int            sel      = 2;
    logic          tb_valid = 1'b0;
    logic [DW-1:0] tb_data  = '0;
    logic          tb_ready = 1'b1;

    assign if_s1.valid_i = tb_valid && (sel == 1);
    assign if_s1.data_i  = tb_data;
    assign if_s1.ready_i = tb_ready;
    assign if_s2.valid_i = tb_valid && (sel == 2);
    assign if_s2.data_i  = tb_data;
    assign if_s2.ready_i = tb_ready;
    assign if_s3.valid_i = tb_valid && (sel == 3);
    assign if_s3.data_i  = tb_data;
    assign if_s3.ready_i = tb_ready;

    logic          mon_valid, mon_ready, mon_last;
    logic [DW-1:0] mon_data;

    always_comb begin
        case (sel)
            1: begin
                mon_valid = if_s1.valid_o; mon_ready = if_s1.ready_o;
                mon_last  = if_s1.last_o;  mon_data  = if_s1.data_o;
            end
            3: begin
                mon_valid = if_s3.valid_o; mon_ready = if_s3.ready_o;
                mon_last  = if_s3.last_o;  mon_data  = if_s3.data_o;
            end
            default: begin
                mon_valid = if_s2.valid_o; mon_ready = if_s2.ready_o;
                mon_last  = if_s2.last_o;  mon_data  = if_s2.data_o;
            end
        endcase
    end

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] in_px[$];
    logic [DW-1:0] exp_data[$];
    logic          exp_last[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: output pixel (ox,oy) is input pixel (ox/scale, oy/scale);
    // zero-insert keeps only positions where both coordinates are multiples of scale.
    task automatic model_frame(input int scale, input int base);
        logic [DW-1:0] frame [LC][LW];
        logic [DW-1:0] px;
        int total;
        int idx;
        for (int y = 0; y < LC; y++) begin
            for (int x = 0; x < LW; x++) begin
                frame[y][x] = (base < 0) ? DW'($urandom) : DW'(base + y * LW + x);
                in_px.push_back(frame[y][x]);
            end
        end
        total = LW * LC * scale * scale;
        idx   = 0;
        for (int oy = 0; oy < LC * scale; oy++) begin
            for (int ox = 0; ox < LW * scale; ox++) begin
                px = frame[oy / scale][ox / scale];
                if (ZI && ((ox % scale) != 0 || (oy % scale) != 0)) px = '0;
                exp_data.push_back(px);
                exp_last.push_back(idx == total - 1);
                idx++;
            end
        end
    endtask

    task automatic run(input int s, input bit rand_valid, input bit rand_ready,
                       input bit full_rate, input int nframes, input int stop_after,
                       input string name);
        int cyc = 0, n_out = 0, n_last = 0, first_in = -1, first_out = -1, gaps = 0, extra = 0;
        bit took = 1'b1, stalled = 1'b0;
        logic [DW-1:0] held = '0;
        logic held_last = 1'b0;
        sel = s;
        while (exp_data.size() > 0 && cyc < 4000 && !(stop_after > 0 && n_out >= stop_after)) begin
            @(posedge clk); #1;
            if (in_px.size() == 0) begin
                tb_valid = 1'b0;
            end else begin
                if (took || !tb_valid) tb_valid = rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1;
                tb_data = in_px[0];
            end
            tb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            cyc++;
            took = tb_valid && mon_ready;
            if (took) begin
                void'(in_px.pop_front());
                if (first_in < 0) first_in = cyc;
            end
            if (mon_valid) begin
                if (first_out < 0) first_out = cyc;
                if (stalled) begin
                    check({name, ":stall_data"}, mon_data, held);
                    check({name, ":stall_last"}, mon_last, held_last);
                end
                if (tb_ready) begin
                    check({name, ":data"}, mon_data, exp_data.pop_front());
                    check({name, ":last"}, mon_last, exp_last.pop_front());
                    n_out++;
                    if (mon_last) n_last++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held      = mon_data;
                    held_last = mon_last;
                end
            end else begin
                if (stalled) check({name, ":stall_valid"}, mon_valid, 1'b1);
                stalled = 1'b0;
                if (first_out >= 0) gaps++;
            end
        end
        if (stop_after == 0) begin
            check({name, ":remaining"}, exp_data.size(), 0);
            check({name, ":last_count"}, n_last, nframes);
            if (full_rate) begin
                check({name, ":latency"}, first_out - first_in, 1);
                check({name, ":bubbles"}, gaps, 0);
            end
            @(posedge clk); #1;
            tb_valid = 1'b0;
            tb_ready = 1'b1;
            repeat (10) begin
                @(negedge clk);
                if (mon_valid) extra++;
            end
            check({name, ":extra_out"}, extra, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        for (int s = 1; s <= 3; s++) begin
            sel = s;
            #1;
            check("reset:valid_o", mon_valid, 1'b0);
            check("reset:data_o", mon_data, '0);
            check("reset:last_o", mon_last, 1'b0);
            check("reset:ready_o", mon_ready, 1'b1);
        end
        @(negedge clk);
        rst = 1'b0;

        model_frame(2, 1);  run(2, 1'b0, 1'b0, 1'b1, 1, 0, "basic");
        model_frame(2, 1);  run(2, 1'b0, 1'b1, 1'b0, 1, 0, "bp_seq");
        model_frame(2, -1); run(2, 1'b1, 1'b1, 1'b0, 1, 0, "bp_rand");
        model_frame(1, 10); run(1, 1'b0, 1'b0, 1'b1, 1, 0, "pass");
        model_frame(1, -1); run(1, 1'b1, 1'b1, 1'b0, 1, 0, "pass_rand");

        model_frame(2, 1);  run(2, 1'b0, 1'b0, 1'b0, 1, 5, "rst_partial");
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst:valid_o", mon_valid, 1'b0);
        check("midrst:last_o", mon_last, 1'b0);
        check("midrst:ready_o", mon_ready, 1'b1);
        in_px.delete();
        exp_data.delete();
        exp_last.delete();
        tb_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_frame(2, 1);  run(2, 1'b0, 1'b0, 1'b1, 1, 0, "after_rst");

        model_frame(3, -1); model_frame(3, -1); run(3, 1'b0, 1'b0, 1'b1, 2, 0, "b2b");
        model_frame(3, -1); run(3, 1'b1, 1'b1, 1'b0, 1, 0, "s3_rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/upsample_layer.md
Name: upsample_layer

Overview:
- Streaming nearest-neighbour upsampler: the spatial inverse of the strided conv layer.
- Accepts a raster-order feature-map stream of LineWidthPx x LineCountPx pixels.
- Emits (LineWidthPx*Scale) x (LineCountPx*Scale) pixels over the same valid/ready handshake.
- Sits between conv stages in the decoder half of the vision pipeline. A single line buffer replays each input row Scale-1 extra times.

Parameters:
- LineWidthPx, 80, input pixels per row (>=2).
- LineCountPx, 60, input rows per frame (>=1).
- DataWidth, 32, bits per pixel, all channels packed.
- Scale, 2, upsample factor in both x and y (1..8). Scale=1 is a pure registered pass-through.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  asynchronous, active-high reset.
- valid_i  input  1  input pixel valid.
- ready_o  output  1  block can accept an input pixel.
- data_i  input  DataWidth  input pixel.
- valid_o  output  1  output pixel valid (registered).
- ready_i  input  1  downstream accepts the output pixel.
- data_o  output  DataWidth  output pixel (registered).
- last_o  output  1  high with valid_o on the final output pixel of a frame.

Behaviour:
- Reset (async assert, sync deassert): valid_o=0, data_o=0, last_o=0, ready_o=1 after reset, FSM=FILL. All counters are 0. Line buffer contents are don't-care.
- Fires: in_fire = valid_i & ready_o; out_fire = valid_o & ready_i.
- Counters:
  - x_in 0..LineWidthPx-1 and y_in 0..LineCountPx-1 count input pixels and rows.
  - h_rep 0..Scale-1 counts horizontal copies of the current pixel.
  - v_rep 0..Scale-1 counts the current replay row.
  - x_in, h_rep and v_rep all wrap to 0.
- State FILL (v_rep=0):
  - ready_o = ~valid_o | (ready_i & h_rep==Scale-1).
  - On in_fire: output register <= data_i, valid_o <= 1, h_rep <= 0, linebuf[x_in] <= data_i.
  - Each out_fire with h_rep<Scale-1 re-presents the same pixel and increments h_rep.
  - After the last copy of the last pixel of the row: if Scale>1 go to REPLAY with v_rep=1, otherwise stay in FILL.
- State REPLAY:
  - ready_o=0.
  - Output pixels come from linebuf[0..LineWidthPx-1], each presented Scale times.
  - Line buffer uses a synchronous read with prefetch. Throughput must be one output per cycle while ready_i=1, with no bubbles, including the FILL->REPLAY and REPLAY->REPLAY row boundaries.
  - At end of a replay row: if v_rep==Scale-1, return to FILL, v_rep=0, and advance y_in (wrap at LineCountPx-1). Otherwise increment v_rep.
  - A REPLAY->FILL bubble is permitted only if valid_i is low.
- Latency: the first output is valid the cycle after the first in_fire.
- Throughput: exactly Scale^2 output cycles per input pixel at full rate.
- Backpressure: while valid_o & ~ready_i, data_o and last_o hold stable and no counter advances.
- last_o is asserted on the output pixel where y_in=LineCountPx-1, v_rep=Scale-1, x_in=LineWidthPx-1, h_rep=Scale-1. The next frame starts in FILL with all counters 0.
- No pixel is ever dropped or duplicated beyond Scale^2 copies. Output count per frame = LineWidthPx*LineCountPx*Scale^2.
- Reset mid-frame discards the partial frame. The first in_fire after reset is treated as pixel (0,0).

Optional Feature:
- UPSAMPLE_ZERO_INSERT_EN defined: zero-insertion mode, the input stage for transposed convolution.
  - Only copy h_rep=0 of row v_rep=0 carries the pixel. All other output positions carry data_o=0.
  - Timing, handshake and last_o are unchanged, and the line buffer is not instantiated.
- Undefined: nearest-neighbour replication as described above.

Test Plan:
- Basic replication: LineWidthPx=4, LineCountPx=2, Scale=2, inputs 1..8, ready_i=1 -> outputs 1,1,2,2,3,3,4,4 twice, then 5,5,6,6,7,7,8,8 twice. 32 outputs, last_o only on the 32nd, ready_o low for 8 cycles per replay row.
- Backpressure: same stimulus with ready_i toggling 1,0 pseudo-randomly -> identical output sequence, data_o stable on every stalled cycle, no extra or missing pixels.
- Pass-through: Scale=1, inputs 10..17 (4x2) -> outputs 10..17, 1-cycle latency, last_o on 17, valid_i=1 and ready_i=1 sustain 1 pixel/cycle.
- Reset mid-frame: assert rst_i asynchronously after 5 outputs of the basic case -> valid_o=0 immediately. A new frame 1..8 then yields the full 32-output sequence from pixel 1.
- Back-to-back frames: two 4x2 frames, Scale=3, valid_i held high -> 72 outputs per frame, last_o exactly twice, second frame starts without any bubble after the first frame's last replay row.
- Zero-insert (with UPSAMPLE_ZERO_INSERT_EN): basic stimulus -> row 0 = 1,0,2,0,3,0,4,0; row 1 all zeros; row 2 = 5,0,6,0,7,0,8,0; row 3 all zeros; last_o on the 32nd output.
